fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch stage. It produces the instruction word and PC pair that the Decode stage consumes, which makes it the upstream end of the Decode inst/PC interface. It owns the fetch PC, issues reads to a 1-cycle-latency instruction memory, and buffers responses in a small skid FIFO so Decode stalls never drop an instruction. It drives the registered IF/ID outputs and handles branch redirects from the later stages.

Parameters:
N, 32, data and address width; matches the Decode width parameter.
DEPTH, 2, skid FIFO entries; must be at least 2.
RESET_PC, 32'h0, fetch address after reset.

Ports:
clk  in  1  clock; all state changes on the rising edge.
rst  in  1  synchronous, active-high reset.
stall  in  1  Decode hazard stall; when 1, the IF/ID outputs hold their value.
branch_taken  in  1  redirect request; takes priority over stall.
branch_target  in  N  redirect address; word-aligned.
imem_en  out  1  read request this cycle.
imem_addr  out  N  read address; equals the fetch PC register.
imem_rdata  in  N  read data; valid exactly 1 cycle after imem_en=1.
inst  out  N  IF/ID instruction to Decode.
PC  out  N  address of the instruction on `inst`.
inst_valid  out  1  1 when inst/PC carry a real instruction.

Behaviour:
- Reset: fetch PC = RESET_PC; FIFO empty; in-flight flag cleared; inst=0, PC=0, inst_valid=0; imem_en=0 during the reset cycle.
- Edge priority: rst > branch_taken > stall > normal operation.
- Issue rule:
  - occ = fifo_count + inflight; pop = !stall && fifo nonempty.
  - imem_en = !rst && !branch_taken && (occ - pop) < DEPTH.
  - On an edge with imem_en=1: inflight <= 1, inflight_pc <= fetch PC, fetch PC <= fetch PC + 4 (wraps modulo 2^N); otherwise inflight <= 0.
- Response: on an edge where inflight=1 and no flush, push {inflight_pc, imem_rdata} into the FIFO.
  - Overflow is impossible by the issue rule; the bench asserts it never occurs.
- IF/ID register:
  - If !stall and the FIFO is nonempty: pop the head into inst/PC and set inst_valid=1.
  - If !stall and the FIFO is empty: inst=0 (NOP), inst_valid=0, PC holds.
  - If stall: inst, PC and inst_valid all hold.
- Flush (branch_taken=1 at an edge):
  - fetch PC <= branch_target; FIFO cleared; inflight <= 0 (the response in the following cycle is discarded).
  - inst <= 0, inst_valid <= 0, regardless of stall.
- Redirect latency:
  - Branch edge E0; request to target in the cycle after E0; push at E2; inst_valid=1 with PC=target after E3.
  - Same 3-edge latency from reset release.
- Throughput: one instruction per cycle in steady state (FIFO count 1, one request in flight).
- Stall release: the buffered instruction appears on the first edge with stall=0; no instruction is duplicated or lost.
- Reset mid-operation: same result as the initial reset; any in-flight response is discarded.

Decomposition:
- Package fetch_pkg:
  - NOP_INST = 32'h0.
  - PC_STEP = 4.
  - Typedef fetch_entry_t = {pc, inst}.
- Sub-module fetch_fifo: parameterised DEPTH, fetch_entry_t storage, synchronous clear, push/pop with count output.

Test Plan:
- The memory model returns rdata = 32'hE000_0000 | addr.
- Reset to RESET_PC=0, then release -> after 3 edges inst=32'hE000_0000, PC=0, valid=1; then PC=4, 8, 12 on consecutive cycles with no bubbles.
- Stall held 3 cycles while PC=8 -> inst/PC frozen at 8; imem_en drops once occ reaches 2; after release PC sequence 12, 16, ... with no gap or repeat.
- Branch_taken with target 32'h100 while a request is in flight -> the stale response is not delivered; valid=0 for 3 cycles, then PC=32'h100, inst=32'hE000_0100.
- Branch_taken and stall high on the same edge -> flush wins; valid=0 next cycle; PC=32'h100 appears once stall is released.
- Rst pulsed for 1 cycle mid-stream with the FIFO full -> all outputs return to 0; restart at PC=0 with 3-edge latency.
- Fetch PC near 2^N-4 (e.g. target 32'hFFFF_FFFC) -> next fetch address wraps to 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0;
  localparam int PC_STEP = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Skid FIFO holding fetched {pc, inst} pairs between the memory response and IF/ID.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clear,
  input  logic         i_push,
  input  fetch_entry_t i_push_data,
  input  logic         i_pop,
  output fetch_entry_t o_head,
  output logic [CW-1:0] o_count,
  output logic         o_empty
);
  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [CW-1:0] r_count;

  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr] <= i_push_data;
        r_wr        <= ptr_next(r_wr);
      end
      if (i_pop) r_rd <= ptr_next(r_rd);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the fetch PC, issues 1-cycle memory reads and feeds the IF/ID register.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int          N        = 32,
  parameter int          DEPTH    = 2,
  parameter logic [N-1:0] RESET_PC = 32'h0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         branch_taken,
  input  logic [N-1:0] branch_target,
  output logic         imem_en,
  output logic [N-1:0] imem_addr,
  input  logic [N-1:0] imem_rdata,
  output logic [N-1:0] inst,
  output logic [N-1:0] PC,
  output logic         inst_valid
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [N-1:0]  r_fetch_pc;
  logic          r_inflight;
  logic [N-1:0]  r_inflight_pc;
  logic [N-1:0]  r_inst;
  logic [N-1:0]  r_pc;
  logic          r_valid;

  logic          w_push;
  logic          w_pop;
  logic          w_fifo_empty;
  logic [CW-1:0] w_fifo_count;
  logic [CW:0]   w_occ;
  logic [CW:0]   w_occ_after_pop;
  fetch_entry_t  w_head;
  fetch_entry_t  w_push_data;

  // A request is only issued if its response is guaranteed a FIFO slot.
  assign w_occ           = {1'b0, w_fifo_count} + (CW+1)'(r_inflight);
  assign w_occ_after_pop = w_occ - (CW+1)'(w_pop);
  assign w_pop           = !stall && !w_fifo_empty;
  assign w_push          = r_inflight && !branch_taken && !rst;
  assign imem_en         = !rst && !branch_taken && (w_occ_after_pop < (CW+1)'(DEPTH));
  assign imem_addr       = r_fetch_pc;

  assign w_push_data.pc   = r_inflight_pc;
  assign w_push_data.inst = imem_rdata;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (branch_taken),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_count     (w_fifo_count),
    .o_empty     (w_fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else if (branch_taken) begin
      r_fetch_pc <= branch_target;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= imem_en;
      if (imem_en) begin
        r_inflight_pc <= r_fetch_pc;
        r_fetch_pc    <= r_fetch_pc + N'(PC_STEP);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_inst  <= '0;
      r_pc    <= '0;
      r_valid <= 1'b0;
    end else if (branch_taken) begin
      r_inst  <= NOP_INST;
      r_valid <= 1'b0;
    end else if (!stall) begin
      if (!w_fifo_empty) begin
        r_inst  <= w_head.inst;
        r_pc    <= w_head.pc;
        r_valid <= 1'b1;
      end else begin
        r_inst  <= NOP_INST;
        r_valid <= 1'b0;
      end
    end
  end

  assign inst       = r_inst;
  assign PC         = r_pc;
  assign inst_valid = r_valid;
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random stall/branch/reset traffic vs a stream model.
module tb_fetch_stage;
  localparam int N = 32;
  localparam int DEPTH = 2;
  localparam logic [N-1:0] RESET_PC = 32'h0;
  localparam logic [N-1:0] MEM_TAG = 32'hE000_0000;

  logic         clk;
  logic         rst;
  logic         stall;
  logic         branch_taken;
  logic [N-1:0] branch_target;
  logic         imem_en;
  logic [N-1:0] imem_addr;
  logic [N-1:0] imem_rdata;
  logic [N-1:0] inst;
  logic [N-1:0] PC;
  logic         inst_valid;

  int n_checks = 0;
  int n_errors = 0;

  // Model: after a redirect/reset the stream starts at a known PC; from the
  // third edge on, every unstalled edge delivers the next word of the stream.
  logic [N-1:0] m_inst, m_pc, m_stream;
  logic         m_valid;
  int           m_phase;

  fetch_stage #(.N(N), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_en       (imem_en),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .inst          (inst),
    .PC            (PC),
    .inst_valid    (inst_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (imem_en) imem_rdata <= MEM_TAG | imem_addr;
  end

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // A response must never arrive to a full FIFO that is not popping that edge.
  always @(negedge clk) begin
    if (!rst && dut.w_push && !dut.w_pop)
      chk("fifo_overflow", {31'b0, dut.w_fifo_count == 2'(DEPTH)}, 32'h0);
  end

  // exp_en: -1 = unchecked, 0/1 = required imem_en for this cycle.
  task automatic step(input logic r, input logic s, input logic b,
                      input logic [N-1:0] t, input int exp_en);
    rst = r; stall = s; branch_taken = b; branch_target = t;
    #1;
    if (r || b) chk("imem_en_off", {31'b0, imem_en}, 32'h0);
    else if (exp_en >= 0) chk("imem_en", {31'b0, imem_en}, N'(exp_en));
    @(posedge clk);
    if (r) begin
      m_inst = '0; m_pc = '0; m_valid = 1'b0; m_phase = 0; m_stream = RESET_PC;
    end else if (b) begin
      m_inst = '0; m_valid = 1'b0; m_phase = 0; m_stream = t;
    end else begin
      if (m_phase < 3) m_phase++;
      if (!s) begin
        if (m_phase >= 3) begin
          m_pc = m_stream; m_inst = MEM_TAG | m_stream; m_valid = 1'b1;
          m_stream = m_stream + 32'd4;
        end else begin
          m_inst = '0; m_valid = 1'b0;
        end
      end
    end
    #1;
    chk("inst", inst, m_inst);
    chk("pc", PC, m_pc);
    chk("inst_valid", {31'b0, inst_valid}, {31'b0, m_valid});
  endtask

  initial begin
    logic [N-1:0] tgt;
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    m_inst = '0; m_pc = '0; m_valid = 1'b0; m_phase = 0; m_stream = RESET_PC;

    // Reset, release, fill: PC 0,4,8 after 3 edges without bubbles
    step(1, 0, 0, 0, -1);
    step(1, 0, 0, 0, -1);
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, -1);
    chk("pc_before_stall", PC, 32'd8);

    // Stall 3 cycles: outputs frozen, no fetch while pipeline full
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, -1);

    // Redirect with a request in flight
    step(0, 0, 1, 32'h100, -1);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, -1);

    // Redirect and stall on the same edge
    step(0, 1, 1, 32'h100, -1);
    step(0, 1, 0, 0, -1);
    step(0, 1, 0, 0, -1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, -1);

    // Reset with FIFO full
    step(0, 1, 0, 0, -1);
    step(0, 1, 0, 0, -1);
    step(1, 0, 0, 0, -1);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, -1);

    // Fetch address wraps past 2^N
    step(0, 0, 1, 32'hFFFF_FFFC, -1);
    chk("addr_at_top", imem_addr, 32'hFFFF_FFFC);
    step(0, 0, 0, 0, 1);
    chk("addr_wrapped", imem_addr, 32'h0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, -1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      tgt = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'hC);
      step($urandom_range(0, 49) == 0, $urandom_range(0, 9) < 3,
           $urandom_range(0, 19) == 0, tgt, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
